// File: rtl/seg_scan_controller.sv
// Scan controller for a common-anode 7-segment bank.
// Ports: wr_* shadow writes, commit/lzs_en controls; code/seg_blank/an_n to the drivers.
module seg_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL = 1024,
  parameter int DEAD = 16,
  localparam int AW = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  wr_blank,
  input  logic                  commit,
  input  logic                  lzs_en,
  output logic [3:0]            code,
  output logic                  seg_blank,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  commit_pending,
  output logic                  commit_done
);

  localparam int MAXC = (DWELL > DEAD) ? DWELL : DEAD;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {
    S_DWELL,
    S_DEAD
  } state_e;

  state_e                          state_q;
  logic [CW-1:0]                   cnt_q;
  logic [AW-1:0]                   idx_q;
  logic [NUM_DIGITS-1:0][3:0]      sh_nib_q, sh_nib_d;
  logic [NUM_DIGITS-1:0]           sh_blk_q, sh_blk_d;
  logic [NUM_DIGITS-1:0][3:0]      act_nib_q;
  logic [NUM_DIGITS-1:0]           act_blk_q;
  logic [NUM_DIGITS-1:0]           lzs_hit;
  logic                            zrun;
  logic                            apply;

  // Shadow including this cycle's write, so a write on the
  // application cycle lands in the active copy too.
  always_comb begin
    sh_nib_d = sh_nib_q;
    sh_blk_d = sh_blk_q;
    if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
      sh_nib_d[wr_addr] = wr_data;
      sh_blk_d[wr_addr] = wr_blank;
    end
  end

  // Zero run scanned from the most significant digit down.
  always_comb begin
    zrun = 1'b1;
    lzs_hit = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zrun = zrun & (act_nib_q[i] == 4'h0);
      lzs_hit[i] = lzs_en & (i != 0) & zrun;
    end
  end

  assign apply = (state_q == S_DEAD) && (cnt_q == '0)
               && commit_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_DEAD;
      cnt_q          <= '0;
      idx_q          <= AW'(NUM_DIGITS - 1);
      sh_nib_q       <= '0;
      sh_blk_q       <= '1;
      act_nib_q      <= '0;
      act_blk_q      <= '1;
      an_n           <= '1;
      code           <= 4'h0;
      seg_blank      <= 1'b1;
      commit_pending <= 1'b0;
      commit_done    <= 1'b0;
    end else begin
      sh_nib_q       <= sh_nib_d;
      sh_blk_q       <= sh_blk_d;
      commit_done    <= apply;
      commit_pending <= commit | (commit_pending & ~apply);
      if (apply) begin
        act_nib_q <= sh_nib_d;
        act_blk_q <= sh_blk_d;
      end
      unique case (state_q)
        S_DWELL: begin
          an_n      <= ~(NUM_DIGITS'(1) << idx_q);
          code      <= act_nib_q[idx_q];
          seg_blank <= act_blk_q[idx_q] | lzs_hit[idx_q];
          if (cnt_q == CW'(DWELL - 1)) begin
            cnt_q   <= '0;
            state_q <= S_DEAD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DEAD: begin
          an_n      <= '1;
          seg_blank <= 1'b1;
          if (cnt_q == CW'(DEAD - 1)) begin
            cnt_q   <= '0;
            state_q <= S_DWELL;
            if (idx_q == AW'(NUM_DIGITS - 1)) idx_q <= '0;
            else idx_q <= idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_DEAD;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller.
// Config NUM_DIGITS=4, DWELL=4, DEAD=1 (20-cycle scan period).
module tb_seg_scan_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       wr_blank = 1'b0;
  logic       commit = 1'b0;
  logic       lzs_en = 1'b0;
  logic [3:0] code;
  logic       seg_blank;
  logic [3:0] an_n;
  logic       commit_pending;
  logic       commit_done;

  int vecs = 0;
  int errs = 0;

  seg_scan_controller #(
    .NUM_DIGITS(4),
    .DWELL(4),
    .DEAD(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_blank(wr_blank),
    .commit(commit),
    .lzs_en(lzs_en),
    .code(code),
    .seg_blank(seg_blank),
    .an_n(an_n),
    .commit_pending(commit_pending),
    .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [1:0] a, input logic [3:0] d,
                    input logic b);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_blank = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] pat, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (an_n === pat) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Leaves the bench on the first cycle digit d is lit.
  task automatic sync_digit(input int d, output bit ok);
    logic [3:0] one;
    bit ok1;
    one = 4'b0001;
    wait_an(4'hF, ok1);
    wait_an(~(one << d), ok);
    ok = ok & ok1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    vecs++;
    if (an_n !== 4'hF) begin
      errs++;
      $display("FAIL rst_an: got %b want 1111", an_n);
    end
    vecs++;
    if (code !== 4'h0) begin
      errs++;
      $display("FAIL rst_code: got %h want 0", code);
    end
    vecs++;
    if (seg_blank !== 1'b1) begin
      errs++;
      $display("FAIL rst_blank: got %b want 1", seg_blank);
    end
    vecs++;
    if ({commit_pending, commit_done} !== 2'b00) begin
      errs++;
      $display("FAIL rst_commit: got %b%b want 00",
               commit_pending, commit_done);
    end
    reset_n = 1'b1;
    @(negedge clk);
    vecs++;
    if ({an_n, seg_blank} !== 5'b11111) begin
      errs++;
      $display("FAIL rst_dead: got %b/%b want 1111/1",
               an_n, seg_blank);
    end
    @(negedge clk);
    vecs++;
    if ({an_n, seg_blank, code} !== {4'b1110, 1'b1, 4'h0}) begin
      errs++;
      $display("FAIL rst_first: got %b/%b/%h want 1110/1/0",
               an_n, seg_blank, code);
    end
  endtask

  task automatic test_write_commit;
    bit ok;
    bit seen;
    logic [3:0] one;
    logic [3:0] exp_an;
    logic [3:0] exp_code;
    logic exp_blk;
    one = 4'b0001;
    wr(2'd3, 4'd1, 1'b0);
    wr(2'd2, 4'd2, 1'b0);
    wr(2'd1, 4'd3, 1'b0);
    wr(2'd0, 4'd4, 1'b0);
    commit = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      commit = 1'b0;
      if (commit_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    vecs++;
    if (seen !== 1'b1) begin
      errs++;
      $display("FAIL wc_done: got %b want 1 within 6", seen);
    end
    sync_digit(0, ok);
    vecs++;
    if (ok !== 1'b1) begin
      errs++;
      $display("FAIL wc_sync: got %b want 1", ok);
    end
    for (int j = 0; j < 20; j++) begin
      if (j != 0) @(negedge clk);
      exp_an = (j % 5 < 4) ? ~(one << (j / 5)) : 4'hF;
      exp_code = 4'(4 - j / 5);
      exp_blk = (j % 5 == 4);
      vecs++;
      if ({an_n, code, seg_blank} !==
          {exp_an, exp_code, exp_blk}) begin
        errs++;
        $display("FAIL wc_scan[%0d]: got %b/%h/%b want %b/%h/%b",
                 j, an_n, code, seg_blank,
                 exp_an, exp_code, exp_blk);
      end
    end
  endtask

  task automatic test_deferred;
    bit ok;
    wr(2'd1, 4'd8, 1'b0);
    sync_digit(1, ok);
    vecs++;
    if (ok !== 1'b1) begin
      errs++;
      $display("FAIL df_sync: got %b want 1", ok);
    end
    commit = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      commit = 1'b0;
      vecs++;
      if ({an_n, code, commit_pending} !== {4'b1101, 4'd3, 1'b1})
      begin
        errs++;
        $display("FAIL df_hold[%0d]: got %b/%h/%b want 1101/3/1",
                 k, an_n, code, commit_pending);
      end
    end
    @(negedge clk);
    vecs++;
    if ({an_n, commit_pending, commit_done} !== {4'hF, 2'b01}) begin
      errs++;
      $display("FAIL df_apply: got %b/%b/%b want 1111/0/1",
               an_n, commit_pending, commit_done);
    end
    @(negedge clk);
    vecs++;
    if ({an_n, code, commit_done} !== {4'b1011, 4'd2, 1'b0}) begin
      errs++;
      $display("FAIL df_next: got %b/%h/%b want 1011/2/0",
               an_n, code, commit_done);
    end
    sync_digit(1, ok);
    vecs++;
    if ({ok, code} !== {1'b1, 4'd8}) begin
      errs++;
      $display("FAIL df_new: got %b/%h want 1/8", ok, code);
    end
  endtask

  task automatic test_merge;
    bit ok;
    int pulses;
    sync_digit(0, ok);
    commit = 1'b1;
    wr_en = 1'b1;
    wr_addr = 2'd2;
    wr_data = 4'd9;
    wr_blank = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    commit = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (commit_done === 1'b1) pulses++;
    end
    vecs++;
    if (pulses !== 1) begin
      errs++;
      $display("FAIL mg_pulses: got %0d want 1", pulses);
    end
    vecs++;
    if (commit_pending !== 1'b0) begin
      errs++;
      $display("FAIL mg_pend: got %b want 0", commit_pending);
    end
    sync_digit(2, ok);
    vecs++;
    if ({ok, code, seg_blank} !== {1'b1, 4'd9, 1'b0}) begin
      errs++;
      $display("FAIL mg_d2: got %b/%h/%b want 1/9/0",
               ok, code, seg_blank);
    end
  endtask

  // A commit landing on the application cycle re-arms pending.
  task automatic test_back_to_back;
    bit ok;
    sync_digit(0, ok);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    vecs++;
    if ({commit_done, commit_pending} !== 2'b11) begin
      errs++;
      $display("FAIL bb_first: got %b%b want 11",
               commit_done, commit_pending);
    end
    for (int i = 0; i < 5; i++) @(negedge clk);
    vecs++;
    if ({commit_done, commit_pending} !== 2'b10) begin
      errs++;
      $display("FAIL bb_second: got %b%b want 10",
               commit_done, commit_pending);
    end
  endtask

  task automatic test_lzs;
    logic [15:0] cfg_nib [4] =
      '{16'h0005, 16'h0000, 16'h0700, 16'h0005};
    logic [3:0] cfg_msk [4] =
      '{4'b1110, 4'b1110, 4'b1000, 4'b0000};
    logic cfg_lzs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] nib;
    logic [3:0] msk;
    bit ok;
    bit seen;
    int d;
    for (int c = 0; c < 4; c++) begin
      nib = cfg_nib[c];
      msk = cfg_msk[c];
      lzs_en = cfg_lzs[c];
      for (int a = 0; a < 4; a++) wr(2'(a), nib[a*4 +: 4], 1'b0);
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (commit_done === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      sync_digit(0, ok);
      vecs++;
      if ({seen, ok} !== 2'b11) begin
        errs++;
        $display("FAIL lz_sync[%0d]: got %b%b want 11", c, seen, ok);
      end
      for (int j = 0; j < 20; j++) begin
        if (j != 0) @(negedge clk);
        if (j % 5 == 1) begin
          d = j / 5;
          vecs++;
          if ({code, seg_blank} !== {nib[d*4 +: 4], msk[d]}) begin
            errs++;
            $display("FAIL lz[%0d] d%0d: got %h/%b want %h/%b",
                     c, d, code, seg_blank, nib[d*4 +: 4], msk[d]);
          end
        end
      end
    end
    lzs_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int bad;
    sync_digit(0, ok);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    vecs++;
    if (commit_pending !== 1'b1) begin
      errs++;
      $display("FAIL rm_pend: got %b want 1", commit_pending);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vecs++;
    if ({an_n, seg_blank, code, commit_pending, commit_done} !==
        {4'hF, 1'b1, 4'h0, 2'b00}) begin
      errs++;
      $display("FAIL rm_async: got %b/%b/%h/%b%b want 1111/1/0/00",
               an_n, seg_blank, code, commit_pending, commit_done);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (commit_done !== 1'b0 || seg_blank !== 1'b1) bad++;
    end
    vecs++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL rm_dark: got %0d bad cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_deferred();
    test_merge();
    test_back_to_back();
    test_lzs();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Time-multiplexed scan controller for the board's common-anode 7-segment display bank. It shares a single hex-to-segment decoder across NUM_DIGITS digits by presenting one digit's nibble at a time on `code` and driving that digit's active-low anode. It holds a shadow and an active digit register set, commits tear-free at digit boundaries, inserts anti-ghosting dead time, and optionally suppresses leading zeros. It sits between the CPU/debug register interface and the external segment decoder/anode drivers.

## Interface
- NUM_DIGITS, 4: digits scanned, >=2; AW = clog2(NUM_DIGITS)
- DWELL, 1024: clk cycles each anode is on, >=1
- DEAD, 16: clk cycles with all anodes off between digits, >=1

- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- wr_en  in  1  write strobe, one shadow entry per cycle
- wr_addr  in  AW  digit index, 0 = least significant
- wr_data  in  4  hex nibble
- wr_blank  in  1  per-digit blank flag written with the nibble
- commit  in  1  request copy of shadow set into active set
- lzs_en  in  1  leading-zero suppression enable
- code  out  4  nibble to the shared segment decoder
- seg_blank  out  1  1 = force segments dark
- an_n  out  NUM_DIGITS  anode enables, active-low, at most one low
- commit_pending  out  1  commit requested, not yet applied
- commit_done  out  1  one-cycle pulse when the active set is updated

## Operation
- Shadow set: per digit, nibble[3:0] and blank. Written on wr_en. wr_addr >= NUM_DIGITS is ignored.
- Active set: same shape. Changes only on a commit application. The scan reads only the active set.
- FSM with two states:
  - DWELL: an_n has the bit for `idx` low. code and seg_blank reflect digit idx. Counter runs 0..DWELL-1. At DWELL-1, go to DEAD.
  - DEAD: an_n is all ones and seg_blank = 1. Counter runs 0..DEAD-1. At DEAD-1, idx advances and the FSM goes to DWELL.
  - idx wraps NUM_DIGITS-1 -> 0.
- Commit:
  - commit sets commit_pending.
  - On the first cycle of DEAD with commit_pending = 1: active <= shadow, commit_pending clears, and commit_done pulses on the next cycle.
  - A commit asserted while commit_pending is already 1 merges into the pending request; no extra pulse.
  - A write on or after the commit cycle, up to and including the application cycle, is captured by that application.
  - A commit asserted on the application cycle itself re-sets commit_pending.
- Per-digit blanking: during DWELL, seg_blank = active blank[idx] OR lzs_hit(idx).
  - lzs_hit(i) = lzs_en AND i != 0 AND active nibbles i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never suppressed.
  - Blank flags do not break a zero run: a blanked zero digit still counts as zero.
- code = active nibble[idx] in DWELL and holds its last value in DEAD.

## Timing
- All outputs are registered and update one cycle after the state or counter change that causes them.
- Reset values:
  - an_n all ones, code 0, seg_blank 1, commit_pending 0, commit_done 0.
  - FSM in DEAD with counter 0 and idx = NUM_DIGITS-1, so the first DWELL is digit 0.
  - Shadow and active nibbles 0, all blank flags 1, so the display is dark until the first commit.
- First anode goes low DEAD+1 cycles after reset_n deasserts.
- Scan period = NUM_DIGITS*(DWELL+DEAD) cycles. Each anode is low for exactly DWELL consecutive cycles.
- Commit latency: at most DWELL+DEAD cycles from commit to application. commit_done follows the application by 1 cycle.
- Reset asserted mid-scan: all outputs return to reset values asynchronously. Any pending commit is lost.

## Test plan
- Reset: hold reset_n low, then release -> an_n=4'b1111, seg_blank=1 for 1+DEAD cycles, then an_n=4'b1110 with seg_blank=1 (blank flags set).
- Write/commit (DWELL=4, DEAD=1): write digits 3..0 = 1,2,3,4 with blank=0, pulse commit -> commit_done within 5 cycles. Over one 20-cycle period code shows 4,3,2,1 on an_n 1110,1101,1011,0111, each low 4 cycles and separated by 1 all-ones cycle.
- Deferred commit: commit mid-DWELL of digit 1 -> active set unchanged until the next DEAD; commit_pending=1 meanwhile; digit 1 shows the old value for its full dwell.
- Simultaneous/merge: commit and write (addr 2, data 9) in the same cycle, then a second commit before application -> a single commit_done, and digit 2 shows 9.
- LZS: active = 0,0,0,5 (d3..d0), lzs_en=1 -> seg_blank=1 for d3..d1, 0 for d0. Active = 0,0,0,0 -> only d0 unblanked showing 0. Active = 0,7,0,0 -> only d3 blanked.
- Reset mid-operation: with a commit pending, assert reset_n low mid-DWELL -> an_n all ones immediately; after release there is no commit_done and the display stays dark.
